// File: rtl/pwl_adc_pkg.sv
// Shared PWL sampling helpers: PWL record layout, time base, evaluation and
// saturating quantization reused by every sampler built on the PWL models.
package pwl_adc_pkg;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int NBIT_MIN      = 2;
  localparam int NBIT_MAX      = 16;
  localparam int LOG2_NAVG_MAX = 4;

  // PWL segment carried as IEEE-754 bit patterns: v(t) = a + b*(t - t0).
  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t0;
  } pwl_t;

  typedef struct packed {
    logic                clip;
    logic [NBIT_MAX-1:0] code;
  } qsample_t;

  // Simulation time in ns (the caller's time unit) converted to seconds.
  function automatic real pwl_time_s(input real t_ns);
    return t_ns * 1.0e-9;
  endfunction

  function automatic real pwl_eval(input pwl_t p, input real t_s);
    return $bitstoreal(p.a) + $bitstoreal(p.b) * (t_s - $bitstoreal(p.t0));
  endfunction

  // floor((v-vlo)*2^nbit/(vhi-vlo)) clamped to [0, 2^nbit-1]; clip marks either rail.
  function automatic qsample_t quantize(input real v, input int nbit,
                                        input real vlo, input real vhi);
    real      x;
    qsample_t r;
    r = '0;
    x = (v - vlo) * real'(1 << nbit) / (vhi - vlo);
    if (x < 0.0) begin
      r.clip = 1'b1;
    end else if (x >= real'(1 << nbit)) begin
      r.clip = 1'b1;
      r.code = NBIT_MAX'((1 << nbit) - 1);
    end else begin
      r.code = NBIT_MAX'(int'($floor(x)));
    end
    return r;
  endfunction
endpackage

// File: rtl/pwl_sample_adc.sv
// Sampling quantizer for a PWL waveform: saturating code per enabled edge,
// 2^log2_navg-sample averaging, one-deep valid/ready output and sticky flags.
module pwl_sample_adc
  import pwl_adc_pkg::*;
#(
  parameter int  nbit      = 8,
  parameter int  log2_navg = 0,
  parameter real vlo       = 0.0,
  parameter real vhi       = 1.0
) (
  input  logic            clk,
  input  logic            reset,
  input  pwl_t            in,
  input  logic            enable,
  output logic [nbit-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            clip,
  output logic            overflow
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int NAVG  = 1 << log2_navg;
  localparam int CNT_W = (log2_navg > 0) ? log2_navg : 1;
  localparam int ACC_W = nbit + log2_navg;

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [nbit-1:0]  dout_reg;
  logic             dout_valid_reg;
  logic             clip_reg;
  logic             overflow_reg;
  logic             last_sample;

  // The waveform is evaluated from inside the clocked process so the time
  // stamp is exactly the rising edge; a continuous evaluation would go stale.
  function automatic logic [nbit-1:0] sample_code(input pwl_t p);
    qsample_t s;
    s = quantize(pwl_eval(p, pwl_time_s($realtime)), nbit, vlo, vhi);
    return s.code[nbit-1:0];
  endfunction

  function automatic logic sample_clip(input pwl_t p);
    qsample_t s;
    s = quantize(pwl_eval(p, pwl_time_s($realtime)), nbit, vlo, vhi);
    return s.clip;
  endfunction

  assign last_sample = enable && (cnt_reg == CNT_W'(NAVG - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      clip_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (enable) begin
        if (sample_clip(in)) begin
          clip_reg <= 1'b1;
        end
        if (last_sample) begin
          acc_reg <= '0;
          cnt_reg <= '0;
        end else begin
          acc_reg <= acc_reg + ACC_W'(sample_code(in));
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      // A new result wins over a plain accept; it is dropped only when the
      // previous one is still pending and not being taken this edge.
      if (last_sample) begin
        if (!dout_valid_reg || dout_ready) begin
          dout_reg       <= nbit'((acc_reg + ACC_W'(sample_code(in))) >> log2_navg);
          dout_valid_reg <= 1'b1;
        end else begin
          overflow_reg <= 1'b1;
        end
      end else if (dout_valid_reg && dout_ready) begin
        dout_valid_reg <= 1'b0;
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign clip       = clip_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_pwl_sample_adc.sv
// Directed bench for pwl_sample_adc: table of single-edge vectors at L=0 plus
// hand sequences for backpressure, reset mid-average and gated enable.
module tb_pwl_sample_adc;
  timeunit 1ns;
  timeprecision 1ps;
  import pwl_adc_pkg::*;

  logic       clk;
  pwl_t       in_pwl;
  logic       rst0, rst1, rst2;
  logic       en0, en1, en2;
  logic       rdy0, rdy1, rdy2;
  logic [7:0] dout0, dout1, dout2;
  logic       v0, v1, v2;
  logic       c0, c1, c2;
  logic       o0, o1, o2;

  int checks   = 0;
  int failures = 0;

  pwl_sample_adc #(.nbit(8), .log2_navg(0), .vlo(0.0), .vhi(1.0)) u_l0 (
    .clk(clk), .reset(rst0), .in(in_pwl), .enable(en0), .dout(dout0),
    .dout_valid(v0), .dout_ready(rdy0), .clip(c0), .overflow(o0));

  pwl_sample_adc #(.nbit(8), .log2_navg(1), .vlo(0.0), .vhi(1.0)) u_l1 (
    .clk(clk), .reset(rst1), .in(in_pwl), .enable(en1), .dout(dout1),
    .dout_valid(v1), .dout_ready(rdy1), .clip(c1), .overflow(o1));

  pwl_sample_adc #(.nbit(8), .log2_navg(2), .vlo(0.0), .vhi(1.0)) u_l2 (
    .clk(clk), .reset(rst2), .in(in_pwl), .enable(en2), .dout(dout2),
    .dout_valid(v2), .dout_ready(rdy2), .clip(c2), .overflow(o2));

  initial clk = 1'b0;
  always #0.5 clk = ~clk;

  typedef struct {
    string name;
    bit    ramp;
    real   a;
    real   frac;
    int    exp_dout;
    bit    exp_clip;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pwl(input real a, input real b, input real t0);
    in_pwl.a  = $realtobits(a);
    in_pwl.b  = $realtobits(b);
    in_pwl.t0 = $realtobits(t0);
  endtask

  // Constant level sitting mid-step of code c.
  task automatic drive_code(input int c);
    set_pwl((real'(c) + 0.5) / 256.0, 0.0, 0.0);
  endtask

  task automatic step();
    @(posedge clk);
    #0.2;
  endtask

  int  exp_v1[8];
  int  exp_d1[8];
  int  codes1[8];
  bit  exp_clip0;
  real t_next;

  initial begin
    vecs[0] = '{"const_half_a",  1'b0,  0.5,     0.0,    128, 1'b0};
    vecs[1] = '{"const_half_b",  1'b0,  0.5,     0.0,    128, 1'b0};
    vecs[2] = '{"ramp_0v2502",   1'b1,  0.0,     0.2502,  64, 1'b0};
    vecs[3] = '{"ramp_0v1",      1'b1,  0.0,     0.1,     25, 1'b0};
    vecs[4] = '{"ramp_0v5005",   1'b1,  0.0,     0.5005, 128, 1'b0};
    vecs[5] = '{"ramp_0v999",    1'b1,  0.0,     0.999,  255, 1'b0};
    vecs[6] = '{"const_zero",    1'b0,  0.0,     0.0,      0, 1'b0};
    vecs[7] = '{"const_top",     1'b0,  0.99999, 0.0,    255, 1'b0};
    vecs[8] = '{"ramp_1v2_clip", 1'b1,  0.0,     1.2,    255, 1'b1};
    vecs[9] = '{"const_neg",     1'b0, -0.3,     0.0,      0, 1'b1};

    codes1 = '{30, 0, 40, 0, 50, 0, 61, 0};
    exp_v1 = '{0, 0, 1, 0, 0, 0, 1, 0};
    exp_d1 = '{0, 0, 35, 35, 35, 35, 55, 55};

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    set_pwl(0.5, 0.0, 0.0);
    repeat (2) step();
    check("rst_dout0", dout0, 0);
    check("rst_valid0", v0, 0);
    check("rst_clip0", c0, 0);
    check("rst_ovf0", o0, 0);
    check("rst_valid1", v1, 0);
    check("rst_valid2", v2, 0);

    // L=0 table: one sample per edge, result visible right after that edge.
    exp_clip0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst0 = 1'b0; en0 = 1'b1; rdy0 = 1'b1;
      t_next = $realtime + 0.5;
      if (vecs[i].ramp) set_pwl(0.0, 1.0e9, (t_next - vecs[i].frac) * 1.0e-9);
      else              set_pwl(vecs[i].a, 0.0, 0.0);
      step();
      exp_clip0 = exp_clip0 | vecs[i].exp_clip;
      $display("vec %s dout=%0d valid=%0d clip=%0d", vecs[i].name, dout0, v0, c0);
      check({vecs[i].name, "_dout"}, dout0, vecs[i].exp_dout);
      check({vecs[i].name, "_valid"}, v0, 1);
      check({vecs[i].name, "_clip"}, c0, exp_clip0);
      check({vecs[i].name, "_ovf"}, o0, 0);
    end

    // Backpressure at L=0: reset wins over enable, then stall for 3 edges.
    @(negedge clk); rst0 = 1'b1; en0 = 1'b1; rdy0 = 1'b1; drive_code(99);
    step();
    $display("bp reset dout=%0d valid=%0d clip=%0d", dout0, v0, c0);
    check("bp_rst_dout", dout0, 0);
    check("bp_rst_valid", v0, 0);
    check("bp_rst_clip", c0, 0);
    @(negedge clk); rst0 = 1'b0; rdy0 = 1'b0; drive_code(20);
    step();
    $display("bp edge1 dout=%0d valid=%0d ovf=%0d", dout0, v0, o0);
    check("bp1_dout", dout0, 20);
    check("bp1_ovf", o0, 0);
    @(negedge clk); drive_code(21);
    step();
    $display("bp edge2 dout=%0d valid=%0d ovf=%0d", dout0, v0, o0);
    check("bp2_dout", dout0, 20);
    check("bp2_ovf", o0, 1);
    @(negedge clk); drive_code(22);
    step();
    $display("bp edge3 dout=%0d valid=%0d ovf=%0d", dout0, v0, o0);
    check("bp3_dout", dout0, 20);
    check("bp3_valid", v0, 1);
    @(negedge clk); rdy0 = 1'b1; drive_code(23);
    step();
    $display("bp accept+load dout=%0d valid=%0d ovf=%0d", dout0, v0, o0);
    check("bp4_dout", dout0, 23);
    check("bp4_valid", v0, 1);
    check("bp4_ovf", o0, 1);
    @(negedge clk); en0 = 1'b0;
    step();
    $display("bp drain dout=%0d valid=%0d", dout0, v0);
    check("bp5_valid", v0, 0);
    check("bp5_dout", dout0, 23);

    // L=2 averaging: 10,11,12,13 -> 11 after the 4th edge only.
    @(negedge clk); rst2 = 1'b0; en2 = 1'b1; rdy2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      drive_code(10 + i);
      step();
      $display("avg4 sample %0d dout=%0d valid=%0d", i, dout2, v2);
      if (i < 3) check("avg4_valid_early", v2, 0);
    end
    check("avg4_dout", dout2, 11);
    check("avg4_valid", v2, 1);
    check("avg4_ovf", o2, 0);

    // Two samples of a partial average, then reset (with enable high).
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive_code(200);
      step();
      $display("partial sample %0d valid=%0d", i, v2);
      check("partial_valid", v2, 0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rst2 = 1'b1; drive_code(250);
      step();
      $display("mid reset %0d dout=%0d valid=%0d clip=%0d ovf=%0d", i, dout2, v2, c2, o2);
      check("midrst_dout", dout2, 0);
      check("midrst_valid", v2, 0);
      check("midrst_flags", {c2, o2}, 0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rst2 = 1'b0; drive_code(4);
      step();
      $display("post reset sample %0d dout=%0d valid=%0d", i, dout2, v2);
      if (i < 3) check("postrst_valid_early", v2, 0);
    end
    check("postrst_dout", dout2, 4);
    check("postrst_valid", v2, 1);

    // L=1 with enable toggling; disabled edges see a clipping level.
    @(negedge clk); rst1 = 1'b0; rdy1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      en1 = (i % 2 == 0);
      if (en1) drive_code(codes1[i]);
      else     set_pwl(2.0, 0.0, 0.0);
      step();
      $display("gate edge %0d en=%0d dout=%0d valid=%0d", i, en1, dout1, v1);
      check("gate_valid", v1, exp_v1[i]);
      if (i >= 2) check("gate_dout", dout1, exp_d1[i]);
    end
    check("gate_clip", c1, 0);
    check("gate_ovf", o1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
